viexo_textctl: RTL and testbench

//  Write scheduler for the text-cell buffer in the font ROM block. Accepts MMIO character

---
 rtl/viexo_pkg.sv | 20 ++
 rtl/viexo_cellctr.sv | 31 +++
 rtl/viexo_textctl.sv | 112 +++++++++++
 tb/tb_viexo_textctl.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/viexo_pkg.sv
// viexo_pkg: shared opcodes, FSM states and default geometry for the text-cell write scheduler.
package viexo_pkg;

    localparam int DEF_ADDR_W = 12;
    localparam int DEF_CHAR_W = 8;
    localparam int DEF_CELLS  = 2400;

    typedef enum logic [1:0] {
        OP_PUT     = 2'b00,
        OP_FILL    = 2'b01,
        OP_PUTNEXT = 2'b10,
        OP_SETCUR  = 2'b11
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_e;

endpackage

// File: rtl/viexo_cellctr.sv
// viexo_cellctr: wrapping 0..CELLS-1 cell counter with clear, load (out-of-range loads give 0) and increment.
module viexo_cellctr #(
    parameter int ADDR_W = 12,
    parameter int CELLS  = 2400
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              ld_i,
    input  logic              inc_i,
    input  logic [ADDR_W-1:0] ld_val_i,
    output logic [ADDR_W-1:0] cnt_o
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(CELLS - 1);

    logic [ADDR_W-1:0] cnt_q, cnt_d;

    always_comb
        cnt_d = clr_i ? '0
              : ld_i  ? (ld_val_i > LAST ? '0 : ld_val_i)
              : inc_i ? (cnt_q == LAST ? '0 : cnt_q + 1'b1)
              : cnt_q;

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;

    assign cnt_o = cnt_q;

endmodule

// File: rtl/viexo_textctl.sv
// viexo_textctl: MMIO character command scheduler and screen fill engine for the text-cell buffer.
// Macro VIEXO_CURSOR_EN enables the PUTNEXT/SETCUR cursor commands; otherwise cursor is tied to 0.
module viexo_textctl
    import viexo_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CHAR_W = DEF_CHAR_W,
    parameter int CELLS  = DEF_CELLS
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [CHAR_W-1:0] cmd_char,
    output logic              busy,
    output logic [ADDR_W:0]   wen_addr,
    output logic [CHAR_W-1:0] wch,
    output logic [ADDR_W-1:0] cursor
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(CELLS - 1);

    state_e            state_q, state_d;
    logic              ready_q, busy_q;
    logic [ADDR_W:0]   wen_q, wen_d;
    logic [CHAR_W-1:0] wch_q, wch_d, fch_q, fch_d;
    logic [ADDR_W-1:0] fill_cnt;
    logic              fill_inc, fill_done, acc;
    op_e               op;

    assign op        = op_e'(cmd_op);
    assign acc       = cmd_valid & ready_q;
    assign fill_done = (state_q == ST_FILL) && (fill_cnt == LAST);

    // fill_cnt rests at 0 in IDLE (wraps there after the last cell, cleared by reset on abort)
    viexo_cellctr #(.ADDR_W(ADDR_W), .CELLS(CELLS)) u_fill_ctr (
        .clk_i(aclk), .rst_i(areset), .clr_i(1'b0), .ld_i(1'b0), .inc_i(fill_inc),
        .ld_val_i('0), .cnt_o(fill_cnt)
    );

`ifdef VIEXO_CURSOR_EN
    logic [ADDR_W-1:0] cur;
    viexo_cellctr #(.ADDR_W(ADDR_W), .CELLS(CELLS)) u_cur_ctr (
        .clk_i(aclk), .rst_i(areset), .clr_i(fill_done),
        .ld_i(acc && op == OP_SETCUR), .inc_i(acc && op == OP_PUTNEXT),
        .ld_val_i(cmd_addr), .cnt_o(cur)
    );
    assign cursor = cur;
`else
    assign cursor = '0;
`endif

    always_comb begin
        state_d  = state_q;
        wen_d    = {1'b0, wen_q[ADDR_W-1:0]};
        wch_d    = wch_q;
        fch_d    = fch_q;
        fill_inc = 1'b0;
        if (state_q == ST_FILL) begin
            wen_d    = {1'b1, fill_cnt};
            wch_d    = fch_q;
            fill_inc = 1'b1;
            state_d  = fill_done ? ST_IDLE : ST_FILL;
        end else if (acc) begin
            case (op)
                OP_PUT: if (cmd_addr <= LAST) begin
                    wen_d = {1'b1, cmd_addr};
                    wch_d = cmd_char;
                end
                OP_FILL: begin
                    state_d  = ST_FILL;
                    fch_d    = cmd_char;
                    wen_d    = {1'b1, fill_cnt};
                    wch_d    = cmd_char;
                    fill_inc = 1'b1;
                end
`ifdef VIEXO_CURSOR_EN
                OP_PUTNEXT: begin
                    wen_d = {1'b1, cur};
                    wch_d = cmd_char;
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge aclk or posedge areset)
        if (areset) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            wen_q   <= '0;
            wch_q   <= '0;
            fch_q   <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= state_d == ST_IDLE;
            busy_q  <= state_d == ST_FILL;
            wen_q   <= wen_d;
            wch_q   <= wch_d;
            fch_q   <= fch_d;
        end

    assign cmd_ready = ready_q;
    assign busy      = busy_q;
    assign wen_addr  = wen_q;
    assign wch       = wch_q;

endmodule

// File: tb/tb_viexo_textctl.sv
// tb_viexo_textctl: directed table-driven bench for viexo_textctl plus fill and reset-abort sequences.
module tb_viexo_textctl;

`ifdef VIEXO_CURSOR_EN
    localparam bit CUR_EN = 1'b1;
`else
    localparam bit CUR_EN = 1'b0;
`endif

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [11:0] cmd_addr = 12'h000;
    logic [7:0]  cmd_char = 8'h00;
    logic        busy;
    logic [12:0] wen_addr;
    logic [7:0]  wch;
    logic [11:0] cursor;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        v;
        logic [1:0]  op;
        logic [11:0] addr;
        logic [7:0]  ch;
        logic        stb;
        logic [11:0] wa;
        logic [7:0]  wd;
        logic [11:0] cur;
    } vec_t;

    vec_t vecs[$];

    viexo_textctl dut (
        .aclk(aclk), .areset(areset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_char(cmd_char), .busy(busy),
        .wen_addr(wen_addr), .wch(wch), .cursor(cursor)
    );

    always #5 aclk = ~aclk;

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    initial begin
        // ops: 00 PUT, 01 FILL, 10 PUTNEXT, 11 SETCUR
        vecs.push_back('{1'b1, 2'b00, 12'h005, 8'h41, 1'b1, 12'h005, 8'h41, 12'h000});
        vecs.push_back('{1'b0, 2'b00, 12'h007, 8'h77, 1'b0, 12'h000, 8'h00, 12'h000});
        vecs.push_back('{1'b1, 2'b00, 12'h000, 8'h41, 1'b1, 12'h000, 8'h41, 12'h000});
        vecs.push_back('{1'b1, 2'b00, 12'h001, 8'h42, 1'b1, 12'h001, 8'h42, 12'h000});
        vecs.push_back('{1'b1, 2'b00, 12'h002, 8'h43, 1'b1, 12'h002, 8'h43, 12'h000});
        vecs.push_back('{1'b0, 2'b00, 12'h000, 8'h00, 1'b0, 12'h000, 8'h00, 12'h000});
        vecs.push_back('{1'b1, 2'b00, 12'h960, 8'h5A, 1'b0, 12'h000, 8'h00, 12'h000});
        vecs.push_back('{1'b1, 2'b00, 12'h95F, 8'h51, 1'b1, 12'h95F, 8'h51, 12'h000});
        vecs.push_back('{1'b1, 2'b11, 12'h95F, 8'h00, 1'b0, 12'h000, 8'h00, CUR_EN ? 12'h95F : 12'h000});
        vecs.push_back('{1'b1, 2'b10, 12'h000, 8'h58, CUR_EN, 12'h95F, 8'h58, 12'h000});
        vecs.push_back('{1'b1, 2'b10, 12'h000, 8'h59, CUR_EN, 12'h000, 8'h59, CUR_EN ? 12'h001 : 12'h000});
        vecs.push_back('{1'b1, 2'b11, 12'h960, 8'h00, 1'b0, 12'h000, 8'h00, 12'h000});
        vecs.push_back('{1'b1, 2'b11, 12'h010, 8'h00, 1'b0, 12'h000, 8'h00, CUR_EN ? 12'h010 : 12'h000});
        vecs.push_back('{1'b1, 2'b10, 12'h3FF, 8'h5A, CUR_EN, 12'h010, 8'h5A, CUR_EN ? 12'h011 : 12'h000});

        repeat (3) @(posedge aclk);
        #1;
        chk("reset outputs", {wen_addr, wch, cursor, busy, cmd_ready}, 32'h0);
        areset = 1'b0;
        step();
        chk("post-reset ready/busy", {cmd_ready, busy}, 2'b10);
        chk("post-reset strobe", wen_addr[12], 1'b0);

        foreach (vecs[k]) begin
            cmd_valid = vecs[k].v;
            cmd_op    = vecs[k].op;
            cmd_addr  = vecs[k].addr;
            cmd_char  = vecs[k].ch;
            step();
            chk($sformatf("vec%0d strobe", k), wen_addr[12], vecs[k].stb);
            if (vecs[k].stb) chk($sformatf("vec%0d addr/data", k), {wen_addr[11:0], wch}, {vecs[k].wa, vecs[k].wd});
            chk($sformatf("vec%0d cursor", k), cursor, vecs[k].cur);
            chk($sformatf("vec%0d ready/busy", k), {cmd_ready, busy}, 2'b10);
        end
        cmd_valid = 1'b0;
        step();
        chk("idle strobe", wen_addr[12], 1'b0);

        // full-screen fill with a PUT held valid throughout
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_char  = 8'h20;
        step();
        cmd_op   = 2'b00;
        cmd_addr = 12'h123;
        cmd_char = 8'h50;
        for (int i = 0; i < 2400; i++) begin
            if (i > 0) step();
            chk($sformatf("fill write %0d", i), {wen_addr, wch, cmd_ready, busy},
                {1'b1, 12'(i), 8'h20, i == 2399, i != 2399});
        end
        chk("cursor after fill", cursor, 12'h000);
        step();
        cmd_valid = 1'b0;
        chk("put after fill", {wen_addr, wch}, {13'h1123, 8'h50});
        chk("ready after fill", {cmd_ready, busy}, 2'b10);
        step();
        chk("strobe drops after put", wen_addr[12], 1'b0);

        // reset in the middle of a fill
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_char  = 8'h2A;
        step();
        cmd_valid = 1'b0;
        repeat (100) step();
        chk("fill write 100", {wen_addr, wch, busy}, {13'h1064, 8'h2A, 1'b1});
        areset = 1'b1;
        #1;
        chk("abort outputs async", {wen_addr, wch, cursor, busy, cmd_ready}, 32'h0);
        step();
        chk("abort outputs at edge", {wen_addr, wch, cursor, busy, cmd_ready}, 32'h0);
        areset = 1'b0;
        step();
        chk("ready after abort", {cmd_ready, busy}, 2'b10);
        begin
            int seen = 0;
            for (int i = 0; i < 30; i++) begin
                if (wen_addr[12] || busy) seen++;
                step();
            end
            chk("no fill resume", seen, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
